// File: rtl/cmac_tx_gate_pkg.sv
// cmac_tx_gate_pkg: shared types and constants for the CMAC TX gate.
package cmac_tx_gate_pkg;

  // Gate FSM states.
  typedef enum logic [1:0] {
    DROP  = 2'd0,
    PASS  = 2'd1,
    ABORT = 2'd2,
    TAIL  = 2'd3
  } gate_state_e;

  // Byte enables of the error-marked terminating beat: byte 0 only.
  localparam int ABORT_TKEEP = 1;

  // Depth of the link_aligned synchronizer.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/cmac_link_settle.sv
// cmac_link_settle: synchronizes the asynchronous PCS alignment flag and
// asserts link_up only after it has been stable for SETTLE_CYCLES clocks.
// Any synchronized 0 clears the count, so link_up drops one clock later.
module cmac_link_settle
  import cmac_tx_gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic link_aligned,
  output logic link_up
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   aligned_s;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;

  // Bring link_aligned into the clk domain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], link_aligned};
    end
  end

  assign aligned_s = sync_q[SYNC_STAGES-1];

  // Count consecutive aligned cycles, parking at the settle threshold.
  always_comb begin
    cnt_d = cnt_q;
    if (!aligned_s) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Settle counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign link_up = (cnt_q == CNT_MAX);

endmodule

// File: rtl/cmac_tx_gate.sv
// cmac_tx_gate: AXI4-Stream gate in front of the CMAC tx_axis port.
// Whole packets pass only while the link is settled; otherwise they are
// discarded. Losing the link mid-packet closes the CMAC-side packet with a
// one-byte, tlast=1, tuser=1 beat and swallows the rest of the input packet.
// Optional statistics counters: define CMAC_TX_GATE_STATS_EN.
module cmac_tx_gate
  import cmac_tx_gate_pkg::*;
#(
  parameter int DATA_WBITS    = 512,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_WBITS     = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    link_aligned,
  input  logic [DATA_WBITS-1:0]   axis_in_tdata,
  input  logic [DATA_WBITS/8-1:0] axis_in_tkeep,
  input  logic                    axis_in_tlast,
  input  logic                    axis_in_tvalid,
  output logic                    axis_in_tready,
  output logic [DATA_WBITS-1:0]   axis_out_tdata,
  output logic [DATA_WBITS/8-1:0] axis_out_tkeep,
  output logic                    axis_out_tlast,
  output logic                    axis_out_tuser,
  output logic                    axis_out_tvalid,
  input  logic                    axis_out_tready,
  output logic                    link_up,
  output logic [CNT_WBITS-1:0]    drop_count,
  output logic [CNT_WBITS-1:0]    abort_count
);

  localparam int KEEP_W = DATA_WBITS / 8;

  gate_state_e state_q;
  gate_state_e state_d;
  logic        in_pkt_q;
  logic        in_pkt_d;
  logic        run_q;
  logic        drop_acc;

  cmac_link_settle #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk          (clk),
    .resetn       (resetn),
    .link_aligned (link_aligned),
    .link_up      (link_up)
  );

  // run_q holds tready low while in reset so every output reads 0 there.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Beat accepted while dropping (DROP always offers ready once running).
  assign drop_acc = axis_in_tvalid & run_q;

  // Packet-boundary tracker on the input side.
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (axis_in_tvalid && axis_in_tready) begin
      in_pkt_d = ~axis_in_tlast;
    end
  end

  // Next state and stream outputs.
  always_comb begin
    state_d         = state_q;
    axis_in_tready  = 1'b0;
    axis_out_tdata  = '0;
    axis_out_tkeep  = '0;
    axis_out_tlast  = 1'b0;
    axis_out_tuser  = 1'b0;
    axis_out_tvalid = 1'b0;
    case (state_q)
      DROP: begin
        axis_in_tready = run_q;
        // Enter PASS only on a packet boundary, including the boundary
        // created by a tlast beat discarded this very cycle.
        if (link_up) begin
          if (in_pkt_q ? (drop_acc && axis_in_tlast)
                       : !(drop_acc && !axis_in_tlast)) begin
            state_d = PASS;
          end
        end
      end
      PASS: begin
        if (!link_up && in_pkt_q &&
            !(axis_in_tvalid && axis_in_tlast && axis_out_tready)) begin
          // Link gone mid-packet and the packet cannot finish now.
          state_d = ABORT;
        end else begin
          axis_out_tdata  = axis_in_tdata;
          axis_out_tkeep  = axis_in_tkeep;
          axis_out_tlast  = axis_in_tlast;
          axis_out_tvalid = axis_in_tvalid;
          axis_in_tready  = axis_out_tready;
          if (!link_up) begin
            if (in_pkt_q) begin
              // Final beat accepted together with the link loss.
              state_d = DROP;
            end else if (!(axis_in_tvalid && axis_out_tready)) begin
              state_d = DROP;
            end
          end
        end
      end
      ABORT: begin
        axis_out_tvalid = 1'b1;
        axis_out_tkeep  = KEEP_W'(ABORT_TKEEP);
        axis_out_tlast  = 1'b1;
        axis_out_tuser  = 1'b1;
        if (axis_out_tready) begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        axis_in_tready = 1'b1;
        if (axis_in_tvalid && axis_in_tlast) begin
          state_d = DROP;
        end
      end
      default: state_d = DROP;
    endcase
  end

  // FSM and packet tracker registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DROP;
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
    end
  end

`ifdef CMAC_TX_GATE_STATS_EN
  logic                 drop_inc;
  logic                 abort_inc;
  logic [CNT_WBITS-1:0] drop_cnt_q;
  logic [CNT_WBITS-1:0] drop_cnt_d;
  logic [CNT_WBITS-1:0] abort_cnt_q;
  logic [CNT_WBITS-1:0] abort_cnt_d;

  // TAIL packets were already counted as aborts, so only DROP counts drops.
  assign drop_inc  = (state_q == DROP) & axis_in_tvalid & axis_in_tready & axis_in_tlast;
  assign abort_inc = (state_q == ABORT) & axis_out_tready;

  // Saturating increments.
  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (drop_inc && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
    if (abort_inc && (abort_cnt_q != '1)) begin
      abort_cnt_d = abort_cnt_q + 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign drop_count  = drop_cnt_q;
  assign abort_count = abort_cnt_q;
`else
  assign drop_count  = '0;
  assign abort_count = '0;
`endif

endmodule
